// File: rtl/mem_arbiter_if.sv
// Bundle between the cache fill FSMs, the store path and main memory.
// The arbiter takes the slave view; the caches plus memory take the master view.
interface mem_arbiter_if;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        d_wr_ack;

    logic        d_fill_req;
    logic [15:0] d_fill_addr;
    logic        i_fill_req;
    logic [15:0] i_fill_addr;

    logic        d_grant;
    logic        i_grant;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        d_fill_valid;
    logic        i_fill_valid;
    logic        d_fill_done;
    logic        i_fill_done;

    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;

    modport slave (
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  d_fill_req, d_fill_addr, i_fill_req, i_fill_addr,
        input  mem_data_in, mem_data_valid,
        output d_wr_ack, d_grant, i_grant,
        output fill_data, fill_word_idx,
        output d_fill_valid, i_fill_valid, d_fill_done, i_fill_done,
        output mem_enable, mem_wr, mem_addr, mem_data_out
    );

    modport master (
        output d_wr_req, d_wr_addr, d_wr_data,
        output d_fill_req, d_fill_addr, i_fill_req, i_fill_addr,
        output mem_data_in, mem_data_valid,
        input  d_wr_ack, d_grant, i_grant,
        input  fill_data, fill_word_idx,
        input  d_fill_valid, i_fill_valid, d_fill_done, i_fill_done,
        input  mem_enable, mem_wr, mem_addr, mem_data_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: D store > D fill > I fill, one transaction outstanding.
// Fills stream one word read per cycle and count returns; return timing is the memory's.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate pending requests
//   WRITE  | one-cycle write-through store, acked this cycle
//   FILL_D | D-cache block fill: issue reads, steer returns to D
//   FILL_I | I-cache block fill: issue reads, steer returns to I
module mem_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] issue_cnt, issue_nxt;
    logic [IDX_W-1:0] ret_cnt, ret_nxt;
    logic [15:0]      base, base_nxt;
    logic             in_fill;

    assign in_fill = (state == FILL_D) || (state == FILL_I);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            base      <= '0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_nxt;
            ret_cnt   <= ret_nxt;
            base      <= base_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        issue_nxt         = issue_cnt;
        ret_nxt           = ret_cnt;
        base_nxt          = base;
        bus.d_wr_ack      = 1'b0;
        bus.d_grant       = 1'b0;
        bus.i_grant       = 1'b0;
        bus.fill_data     = '0;
        bus.fill_word_idx = '0;
        bus.d_fill_valid  = 1'b0;
        bus.i_fill_valid  = 1'b0;
        bus.d_fill_done   = 1'b0;
        bus.i_fill_done   = 1'b0;
        bus.mem_enable    = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_data_out  = '0;

        case (state)
            IDLE: begin
                issue_nxt = '0;
                ret_nxt   = '0;
                if (bus.d_wr_req) begin
                    state_nxt = WRITE;
                end else if (bus.d_fill_req) begin
                    state_nxt = FILL_D;
                    base_nxt  = bus.d_fill_addr & 16'hFFF0;
                end else if (bus.i_fill_req) begin
                    state_nxt = FILL_I;
                    base_nxt  = bus.i_fill_addr & 16'hFFF0;
                end
            end

            WRITE: begin
                bus.mem_enable   = 1'b1;
                bus.mem_wr       = 1'b1;
                bus.mem_addr     = bus.d_wr_addr;
                bus.mem_data_out = bus.d_wr_data;
                bus.d_wr_ack     = 1'b1;
                state_nxt        = IDLE;
            end

            FILL_D, FILL_I: begin
                bus.d_grant   = (state == FILL_D);
                bus.i_grant   = (state == FILL_I);
                bus.fill_data = bus.mem_data_in;
                if (issue_cnt < ISSUE_END) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = base + 16'({issue_cnt[IDX_W-1:0], 1'b0});
                    issue_nxt      = issue_cnt + CNT_W'(1);
                end
                // Returns are counted, not timed: whatever arrives is the next word.
                if (bus.mem_data_valid) begin
                    bus.fill_word_idx = ret_cnt;
                    bus.d_fill_valid  = (state == FILL_D);
                    bus.i_fill_valid  = (state == FILL_I);
                    ret_nxt           = ret_cnt + IDX_W'(1);
                    if (ret_cnt == LAST_IDX) begin
                        bus.d_fill_done = (state == FILL_D);
                        bus.i_fill_done = (state == FILL_I);
                        state_nxt       = IDLE;
                        issue_nxt       = '0;
                        ret_nxt         = '0;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // A word can never come back sooner than the memory latency after its read.
    a_no_early_return: assert property (@(posedge clk) disable iff (!rst_n)
        (in_fill && bus.mem_data_valid) |->
        (int'(issue_cnt) >= ((int'(ret_cnt) + MEM_LATENCY < WORDS_PER_BLOCK) ?
                             int'(ret_cnt) + MEM_LATENCY : WORDS_PER_BLOCK)));
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios then random traffic, each cycle
// checked against a transaction-level model of the arbiter and a 4-cycle memory.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MEM_LATENCY(4), .WORDS_PER_BLOCK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int K_IDLE = 0, K_WR = 1, K_FD = 2, K_FI = 3;
    localparam int LAT = 4;

    typedef struct {int due; logic [15:0] data;} ret_t;
    ret_t mq[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int m_kind = K_IDLE, m_off = 0, m_rets = 0;
    logic [15:0] m_base = '0;
    bit m_known = 0;

    bit drop_dwr = 0, drop_df = 0, drop_if = 0;
    bit want_dwr = 0, want_df = 0, want_if = 0, want_rst = 0;
    logic [15:0] want_dwr_addr, want_dwr_data, want_df_addr, want_if_addr;
    bit rand_en = 0, chk_zero = 0;
    int cnt_dv = 0, cnt_iv = 0, cnt_ack = 0, cnt_dd = 0, cnt_id = 0;

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_counts();
        cnt_dv = 0; cnt_iv = 0; cnt_ack = 0; cnt_dd = 0; cnt_id = 0;
    endtask

    task automatic cycle1();
        logic [8:0]  ctl_e, ctl_g;
        logic [2:0]  idx_e;
        logic [15:0] addr_e, dout_e;
        logic        en_e, dv_e, done_e, fd, fi;
        @(negedge clk);
        if (want_rst) begin
            rst_n = 1'b0;
            bus.d_wr_req = 1'b0; bus.d_fill_req = 1'b0; bus.i_fill_req = 1'b0;
            drop_dwr = 0; drop_df = 0; drop_if = 0;
            want_rst = 0;
        end else begin
            rst_n = 1'b1;
        end

        if (drop_dwr) begin
            bus.d_wr_req = 1'b0; drop_dwr = 0;
        end else if (rst_n && !bus.d_wr_req && (want_dwr || (rand_en && $urandom_range(0, 9) == 0))) begin
            bus.d_wr_req  = 1'b1;
            bus.d_wr_addr = want_dwr ? want_dwr_addr : 16'($urandom);
            bus.d_wr_data = want_dwr ? want_dwr_data : 16'($urandom);
            want_dwr = 0;
        end
        if (drop_df) begin
            bus.d_fill_req = 1'b0; drop_df = 0;
        end else if (rst_n && !bus.d_fill_req && (want_df || (rand_en && $urandom_range(0, 5) == 0))) begin
            bus.d_fill_req  = 1'b1;
            bus.d_fill_addr = want_df ? want_df_addr : 16'($urandom);
            want_df = 0;
        end
        if (drop_if) begin
            bus.i_fill_req = 1'b0; drop_if = 0;
        end else if (rst_n && !bus.i_fill_req && (want_if || (rand_en && $urandom_range(0, 5) == 0))) begin
            bus.i_fill_req  = 1'b1;
            bus.i_fill_addr = want_if ? want_if_addr : 16'($urandom);
            want_if = 0;
        end

        if (mq.size() > 0 && mq[0].due == cyc) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = mq[0].data;
            void'(mq.pop_front());
        end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data_in    = 16'($urandom);
        end

        #1;
        ctl_e = '0; idx_e = '0; addr_e = '0; dout_e = '0; en_e = 0; dv_e = 0; done_e = 0;
        fd = (m_kind == K_FD);
        fi = (m_kind == K_FI);
        if (m_kind == K_WR) begin
            ctl_e  = 9'b1_0000_0011;
            addr_e = bus.d_wr_addr;
            dout_e = bus.d_wr_data;
            en_e   = 1;
        end else if (fd || fi) begin
            en_e   = (m_off < 8);
            addr_e = en_e ? m_base + 16'(2 * m_off) : 16'h0;
            dv_e   = bus.mem_data_valid;
            done_e = dv_e && (m_rets == 7);
            idx_e  = dv_e ? 3'(m_rets) : 3'd0;
            ctl_e  = {1'b0, fd, fi, dv_e & fd, dv_e & fi, done_e & fd, done_e & fi, en_e, 1'b0};
        end
        ctl_g = {bus.d_wr_ack, bus.d_grant, bus.i_grant, bus.d_fill_valid, bus.i_fill_valid,
                 bus.d_fill_done, bus.i_fill_done, bus.mem_enable, bus.mem_wr};

        if (m_known) begin
            chk("ctl_idx", {ctl_g, bus.fill_word_idx}, {ctl_e, idx_e});
            if (m_kind == K_IDLE || en_e) chk("mem_addr", bus.mem_addr, addr_e);
            chk("mem_data_out", bus.mem_data_out, dout_e);
            if (dv_e) chk("fill_data", bus.fill_data, mem_word(m_base + 16'(2 * m_rets)));
        end
        if (chk_zero) begin
            chk("reset_all_zero", {ctl_g, bus.fill_word_idx, bus.mem_addr, bus.mem_data_out, bus.fill_data}, '0);
            chk_zero = 0;
        end

        if (bus.d_wr_ack === 1'b1)     begin drop_dwr = 1; cnt_ack++; end
        if (bus.d_fill_done === 1'b1)  begin drop_df = 1; cnt_dd++; end
        if (bus.i_fill_done === 1'b1)  begin drop_if = 1; cnt_id++; end
        if (bus.d_fill_valid === 1'b1) cnt_dv++;
        if (bus.i_fill_valid === 1'b1) cnt_iv++;
        if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0)
            mq.push_back('{cyc + LAT, mem_word(bus.mem_addr)});

        if (!rst_n) begin
            m_kind = K_IDLE; m_off = 0; m_rets = 0; m_known = 1;
        end else if (m_known) begin
            case (m_kind)
                K_IDLE: begin
                    m_off = 0; m_rets = 0;
                    if (bus.d_wr_req) m_kind = K_WR;
                    else if (bus.d_fill_req) begin m_kind = K_FD; m_base = bus.d_fill_addr & 16'hFFF0; end
                    else if (bus.i_fill_req) begin m_kind = K_FI; m_base = bus.i_fill_addr & 16'hFFF0; end
                end
                K_WR: m_kind = K_IDLE;
                default: begin
                    if (done_e) m_kind = K_IDLE;
                    else begin
                        m_off++;
                        if (dv_e) m_rets++;
                    end
                end
            endcase
        end
        cyc++;
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle1();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
        bus.d_fill_req = 0; bus.d_fill_addr = '0;
        bus.i_fill_req = 0; bus.i_fill_addr = '0;
        bus.mem_data_in = '0; bus.mem_data_valid = 0;

        for (int k = 0; k < 3; k++) begin want_rst = 1; cycle1(); end

        // single I fill from a misaligned address
        clr_counts();
        want_if = 1; want_if_addr = 16'h1236;
        run(20);
        chk("t1_i_valids", 64'(cnt_iv), 64'd8);
        chk("t1_i_done", 64'(cnt_id), 64'd1);
        chk("t1_d_valids", 64'(cnt_dv), 64'd0);

        // D and I fills raised together
        clr_counts();
        want_df = 1; want_df_addr = 16'h0040;
        want_if = 1; want_if_addr = 16'h2000;
        run(40);
        chk("t2_d_valids", 64'(cnt_dv), 64'd8);
        chk("t2_i_valids", 64'(cnt_iv), 64'd8);

        // store together with a D fill
        clr_counts();
        want_dwr = 1; want_dwr_addr = 16'h0100; want_dwr_data = 16'hBEEF;
        want_df = 1; want_df_addr = 16'h0468;
        run(25);
        chk("t3_acks", 64'(cnt_ack), 64'd1);
        chk("t3_d_valids", 64'(cnt_dv), 64'd8);

        // store raised in the middle of an I fill
        clr_counts();
        want_if = 1; want_if_addr = 16'h3338;
        run(6);
        want_dwr = 1; want_dwr_addr = 16'h0202; want_dwr_data = 16'h1234;
        run(25);
        chk("t4_acks", 64'(cnt_ack), 64'd1);
        chk("t4_i_valids", 64'(cnt_iv), 64'd8);

        // reset after four words of a D fill
        want_df = 1; want_df_addr = 16'h0A0A;
        for (int k = 0; k < 30; k++) begin
            if (m_kind == K_FD && m_rets == 4) break;
            cycle1();
        end
        chk("t5_reached_word4", 64'(m_kind == K_FD && m_rets == 4), 64'd1);
        want_rst = 1;
        cycle1();
        clr_counts();
        chk_zero = 1;
        run(10);
        chk("t5_late_d_valids", 64'(cnt_dv + cnt_iv), 64'd0);
        chk("t5_late_dones", 64'(cnt_dd + cnt_id), 64'd0);
        clr_counts();
        want_df = 1; want_df_addr = 16'h0C00;
        run(20);
        chk("t5_refill_valids", 64'(cnt_dv), 64'd8);

        // stray return while idle
        run(3);
        clr_counts();
        mq.push_back('{cyc, 16'hFFFF});
        run(4);
        chk("t6_stray_valids", 64'(cnt_dv + cnt_iv), 64'd0);
        chk("t6_stray_dones", 64'(cnt_dd + cnt_id), 64'd0);

        // random traffic, then drain
        rand_en = 1;
        run(1500);
        rand_en = 0;
        run(80);
        chk("drain_idle", 64'(m_kind), 64'(K_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache and D-cache fill FSMs and the single-port, pipelined, multi-cycle main memory.
- Arbitrates three request types: D-cache write-through store, D-cache block fill and I-cache block fill.
- For a fill, it issues one word read per cycle for a whole 16-byte block and steers the returned words to the granted cache with a word index.
- The fill FSMs see it as "the memory"; the memory sees a single well-formed request stream.

Parameters:
MEM_LATENCY, 4, cycles from mem_enable (read) to matching mem_data_valid; arbiter only counts returns, never times them
WORDS_PER_BLOCK, 8, 16-bit words per cache block (16 bytes)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
d_wr_req  in  1  D-cache store request, held until d_wr_ack
d_wr_addr  in  16  store byte address
d_wr_data  in  16  store data
d_wr_ack  out  1  one-cycle pulse, store issued to memory
d_fill_req  in  1  D-cache miss fill request, held until d_fill_done
d_fill_addr  in  16  D miss address
i_fill_req  in  1  I-cache miss fill request, held until i_fill_done
i_fill_addr  in  16  I miss address
d_grant  out  1  D fill in progress
i_grant  out  1  I fill in progress
fill_data  out  16  returned word, equals mem_data_in
fill_word_idx  out  3  index of returned word within the block
d_fill_valid  out  1  fill_data valid for D-cache
i_fill_valid  out  1  fill_data valid for I-cache
d_fill_done  out  1  one-cycle pulse with last D word
i_fill_done  out  1  one-cycle pulse with last I word
mem_enable  out  1  memory request strobe
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  16  memory byte address
mem_data_out  out  16  write data
mem_data_in  in  16  memory read data
mem_data_valid  in  1  read data valid

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE, issue_cnt = 0, ret_cnt = 0. All outputs 0 from the following cycle, including mem_* and every grant, valid, ack and done.
- A reset mid-operation aborts the transaction. Memory returns still in flight after reset arrive in IDLE and are ignored.
- States: IDLE, WRITE, FILL_D, FILL_I.
- IDLE arbitration at each rising edge, fixed priority d_wr_req > d_fill_req > i_fill_req:
  - d_wr_req wins: go to WRITE.
  - d_fill_req wins: go to FILL_D and latch base = d_fill_addr & 16'hFFF0.
  - i_fill_req wins: go to FILL_I and latch base = i_fill_addr & 16'hFFF0.
- WRITE, one cycle:
  - Outputs: mem_enable = 1, mem_wr = 1, mem_addr = d_wr_addr, mem_data_out = d_wr_data, d_wr_ack = 1.
  - Always returns to IDLE. The requester drops d_wr_req on the ack, so the next IDLE sees it low.
- FILL_x, where x is the granted cache:
  - x_grant = 1 for the entire state. Latency is counted from the arbitration edge N.
  - Issue phase: cycles N+1 .. N+8 drive mem_enable = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt, with issue_cnt going 0..7. mem_enable = 0 once issue_cnt = WORDS_PER_BLOCK.
  - Return phase, overlaps the issue phase: each cycle with mem_data_valid = 1 drives x_fill_valid = 1, fill_data = mem_data_in, fill_word_idx = ret_cnt, then ret_cnt increments.
  - The 8th valid (ret_cnt = 7) also drives x_fill_done = 1. The next edge goes to IDLE and clears both counters.
  - The first word nominally arrives at N+1+MEM_LATENCY; the last word and done at N+8+MEM_LATENCY.
  - The requester drops x_fill_req on done, so the following IDLE sees it low.
- Strict request ordering: at most one transaction is outstanding. A new grant starts no earlier than the cycle after done.
  - Consequence: a D store waiting behind an I fill waits the full fill, including drain.
- Requests arriving while not in IDLE are not acknowledged. They are only sampled in IDLE.
- mem_data_valid ignored in IDLE and in WRITE. In FILL_x, valids beyond the 8th are impossible, since the state leaves on the 8th.
- fill_data is combinational pass-through of mem_data_in. fill_word_idx is 0 when no valid is present.
- The non-granted cache's valid, done and grant stay 0 throughout.
- Address arithmetic is 16-bit, no carry out. base is block-aligned, so base + 14 never wraps across a block.
- Simultaneous d_fill_req and i_fill_req with the D fill granted: i_fill_req stays pending, and I is granted in the IDLE cycle after d_fill_done, if nothing of higher priority is pending.

Test Plan:
1. Reset, then i_fill_req = 1, i_fill_addr = 16'h1236 -> i_grant from the next cycle. mem_addr = 1230, 1232, ..., 123E on 8 consecutive cycles, mem_wr = 0. Memory returns A0..A7 -> i_fill_valid with fill_word_idx 0..7, i_fill_done on A7, i_grant drops the following cycle.
2. d_fill_req and i_fill_req both asserted in the same IDLE cycle (addrs 16'h0040 and 16'h2000) -> D fill completes entirely (reads 0040..004E) first. I fill (reads 2000..200E) starts the cycle after IDLE is re-entered. i_fill_valid stays 0 during the D fill.
3. d_wr_req (addr 16'h0100, data 16'hBEEF) together with d_fill_req -> one cycle with mem_enable = 1, mem_wr = 1, mem_addr = 0100, mem_data_out = BEEF, d_wr_ack = 1. The D fill is then granted on the next IDLE.
4. d_wr_req raised mid-I-fill -> no d_wr_ack until the cycle after i_fill_done plus one IDLE cycle. Store parameters are unchanged when issued.
5. Assert rst_n = 0 after 4 words of a D fill -> all outputs 0. The 4 late mem_data_valid pulses produce no d_fill_valid. A subsequent fill returns fill_word_idx starting at 0.
6. Stray mem_data_valid in IDLE with data 16'hFFFF -> no fill_valid or done on either side, state remains IDLE.
